// File: rtl/tl_pkg.sv
// Shared definitions for the intersection controller: state codes, interval selects
// and lamp encodings. Also used by the time-parameter block.
package tl_pkg;

   typedef enum logic [2:0] {
      StInit  = 3'd0,
      StMg    = 3'd1,
      StMgExt = 3'd2,
      StMy    = 3'd3,
      StWalk  = 3'd4,
      StSg    = 3'd5,
      StSgExt = 3'd6,
      StSy    = 3'd7
   } tl_state_e;

   typedef enum logic [1:0] {
      SelBase = 2'b00,
      SelExt  = 2'b01,
      SelYel  = 2'b10
   } tl_sel_e;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   typedef struct packed {
      logic [2:0] main;
      logic [2:0] side;
      logic       walk;
   } lamps_t;

   // Unknown states fall back to all-red so the two roads never conflict.
   function automatic lamps_t lamps_of(tl_state_e st);
      lamps_t l;
      l = '{main: LAMP_R, side: LAMP_R, walk: 1'b0};
      case (st)
         StMg, StMgExt: l.main = LAMP_G;
         StMy:          l.main = LAMP_Y;
         StSg, StSgExt: l.side = LAMP_G;
         StSy:          l.side = LAMP_Y;
         StWalk:        l.walk = 1'b1;
         default:       l = '{main: LAMP_R, side: LAMP_R, walk: 1'b0};
      endcase
      return l;
   endfunction

endpackage

// File: rtl/tl_sync.sv
// N-stage flop synchroniser for an asynchronous level input.
module tl_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/traffic_light_fsm.sv
// Intersection sequencing controller: steps main/side/walk phases on Timer expiry,
// reloading the Timer with a one-cycle start pulse on every state entry.
module traffic_light_fsm
   import tl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned IGNORE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       Reset_n,
   input  logic       expired,
   input  logic       sensor,
   input  logic       walk_request,
   output logic       start_timer,
   output logic [1:0] interval_sel,
   output logic [2:0] main_lamp,
   output logic [2:0] side_lamp,
   output logic       walk_lamp,
   output logic [2:0] state_dbg
);

   localparam int unsigned CntW = (IGNORE_CYCLES > 0) ? $clog2(IGNORE_CYCLES + 1) : 1;

   tl_state_e     state_q, state_d;
   tl_sel_e       sel_q, sel_d;
   lamps_t        lamps_q, lamps_d;
   logic          start_q, start_d;
   logic [CntW-1:0] ign_q, ign_d;
   logic          pend_q, pend_d;
   logic          walk_prev_q;
   logic          sensor_s, walk_s;
   logic          accept, enter;

   tl_sync #(.STAGES(SYNC_STAGES)) u_sync_sensor (
      .clk   (clk),
      .rst_n (Reset_n),
      .d     (sensor),
      .q     (sensor_s)
   );

   tl_sync #(.STAGES(SYNC_STAGES)) u_sync_walk (
      .clk   (clk),
      .rst_n (Reset_n),
      .d     (walk_request),
      .q     (walk_s)
   );

   // Expiries arriving while the Timer is still reloading belong to the old interval.
   assign accept = expired && (ign_q == '0);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      enter   = 1'b0;
      unique case (state_q)
         StInit: begin
            state_d = StMg;
            sel_d   = SelBase;
            enter   = 1'b1;
         end
         StMg: if (accept) begin
            enter = 1'b1;
            if (sensor_s || pend_q) begin
               state_d = StMgExt;
               sel_d   = SelExt;
            end else begin
               state_d = StMg;
               sel_d   = SelBase;
            end
         end
         StMgExt: if (accept) begin
            enter   = 1'b1;
            state_d = StMy;
            sel_d   = SelYel;
         end
         StMy: if (accept) begin
            enter   = 1'b1;
            state_d = pend_q ? StWalk : StSg;
            sel_d   = SelBase;
         end
         StWalk: if (accept) begin
            enter   = 1'b1;
            state_d = StSg;
            sel_d   = SelBase;
         end
         StSg: if (accept) begin
            enter   = 1'b1;
            state_d = sensor_s ? StSgExt : StSy;
            sel_d   = sensor_s ? SelExt : SelYel;
         end
         StSgExt: if (accept) begin
            enter   = 1'b1;
            state_d = StSy;
            sel_d   = SelYel;
         end
         StSy: if (accept) begin
            enter   = 1'b1;
            state_d = StMg;
            sel_d   = SelBase;
         end
         default: begin
            state_d = StInit;
            sel_d   = SelBase;
         end
      endcase

      start_d = enter;
      lamps_d = lamps_of(state_d);

      if (enter) begin
         ign_d = CntW'(IGNORE_CYCLES);
      end else if (ign_q != '0) begin
         ign_d = ign_q - CntW'(1);
      end else begin
         ign_d = ign_q;
      end

      // A new press in the WALK-entry cycle survives and is served next round.
      pend_d = pend_q;
      if (enter && (state_d == StWalk)) pend_d = 1'b0;
      if (walk_s && !walk_prev_q)       pend_d = 1'b1;
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= StInit;
         sel_q       <= SelBase;
         lamps_q     <= '{main: LAMP_R, side: LAMP_R, walk: 1'b0};
         start_q     <= 1'b0;
         ign_q       <= '0;
         pend_q      <= 1'b0;
         walk_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         lamps_q     <= lamps_d;
         start_q     <= start_d;
         ign_q       <= ign_d;
         pend_q      <= pend_d;
         walk_prev_q <= walk_s;
      end
   end

   assign start_timer  = start_q;
   assign interval_sel = sel_q;
   assign main_lamp    = lamps_q.main;
   assign side_lamp    = lamps_q.side;
   assign walk_lamp    = lamps_q.walk;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Randomised scoreboard bench: the driver predicts each state entry and queues it,
// a negedge monitor pops on every start_timer pulse and checks outputs every cycle.
module tb_traffic_light_fsm;
   import tl_pkg::*;

   logic       clk = 1'b0;
   logic       Reset_n;
   logic       expired, sensor, walk_request;
   logic       start_timer, walk_lamp;
   logic [1:0] interval_sel;
   logic [2:0] main_lamp, side_lamp, state_dbg;

   traffic_light_fsm #(.SYNC_STAGES(2), .IGNORE_CYCLES(2)) dut (
      .clk          (clk),
      .Reset_n      (Reset_n),
      .expired      (expired),
      .sensor       (sensor),
      .walk_request (walk_request),
      .start_timer  (start_timer),
      .interval_sel (interval_sel),
      .main_lamp    (main_lamp),
      .side_lamp    (side_lamp),
      .walk_lamp    (walk_lamp),
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {
      int        cyc;
      tl_state_e st;
   } exp_t;

   exp_t      exp_q[$];
   int        cyc = 0;
   int        total = 0;
   int        bad = 0;
   tl_state_e m_state = StInit;
   bit        m_pend = 1'b0;
   tl_state_e cur = StInit;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input int act, input int req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference view of the phase table.
   function automatic int exp_main(tl_state_e s);
      if (s == StMg || s == StMgExt) return 1;
      if (s == StMy) return 2;
      return 4;
   endfunction

   function automatic int exp_side(tl_state_e s);
      if (s == StSg || s == StSgExt) return 1;
      if (s == StSy) return 2;
      return 4;
   endfunction

   function automatic int exp_sel(tl_state_e s);
      if (s == StMgExt || s == StSgExt) return 1;
      if (s == StMy || s == StSy) return 2;
      return 0;
   endfunction

   function automatic tl_state_e model_next(tl_state_e s, bit sen, bit pend);
      case (s)
         StMg:    return (sen || pend) ? StMgExt : StMg;
         StMgExt: return StMy;
         StMy:    return pend ? StWalk : StSg;
         StWalk:  return StSg;
         StSg:    return sen ? StSgExt : StSy;
         StSgExt: return StSy;
         StSy:    return StMg;
         default: return StMg;
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!Reset_n) begin
         cur = StInit;
         check(start_timer == 1'b0, "reset_start", int'(start_timer), 0);
      end else if (start_timer) begin
         if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_start", int'(state_dbg), -1);
         end else begin
            e = exp_q.pop_front();
            check(cyc == e.cyc, "entry_cycle", cyc, e.cyc);
            cur = e.st;
         end
      end
      check(state_dbg == 3'(cur), "state", int'(state_dbg), int'(cur));
      check(int'(main_lamp) == exp_main(cur), "main_lamp", int'(main_lamp), exp_main(cur));
      check(int'(side_lamp) == exp_side(cur), "side_lamp", int'(side_lamp), exp_side(cur));
      check(walk_lamp == (cur == StWalk), "walk_lamp", int'(walk_lamp), int'(cur == StWalk));
      check(int'(interval_sel) == exp_sel(cur), "interval_sel", int'(interval_sel), exp_sel(cur));
      check(main_lamp == LAMP_R || side_lamp == LAMP_R, "one_road_red",
            int'({main_lamp, side_lamp}), -1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      m_pend  = 1'b0;
      repeat (3) tick();
      Reset_n = 1'b1;
      exp_q.push_back('{cyc: cyc + 1, st: StMg});
      m_state = StMg;
      tick();
   endtask

   // Called in a start cycle; returns in the next start cycle.
   task automatic step(input bit sen, input bit press, input int d, input bit drop);
      tl_state_e nx;
      sensor = sen;
      if (press) begin
         walk_request = 1'b1;
         m_pend       = 1'b1;
      end
      tick();
      walk_request = 1'b0;
      if (drop) expired = 1'b1;
      tick();
      expired = 1'b0;
      repeat (d - 2) tick();
      nx = model_next(m_state, sen, m_pend);
      if (nx == StWalk) m_pend = 1'b0;
      expired = 1'b1;
      exp_q.push_back('{cyc: cyc + 1, st: nx});
      tick();
      expired = 1'b0;
      m_state = nx;
   endtask

   initial begin
      Reset_n      = 1'b1;
      expired      = 1'b0;
      sensor       = 1'b0;
      walk_request = 1'b0;
      #1;
      do_reset();

      step(1'b0, 1'b0, 5, 1'b0);
      step(1'b1, 1'b0, 5, 1'b0);
      step(1'b1, 1'b0, 4, 1'b0);
      step(1'b0, 1'b0, 4, 1'b0);
      step(1'b0, 1'b1, 5, 1'b0);
      repeat (5) step(1'b0, 1'b0, 4, 1'b0);
      step(1'b0, 1'b0, 3, 1'b1);

      for (int i = 0; i < 150; i++) begin
         step(1'($urandom % 2), ($urandom % 4) == 0, int'($urandom_range(3, 8)),
              ($urandom % 3) == 0);
      end

      for (int i = 0; i < 40 && m_state != StSg; i++) begin
         step(1'($urandom % 2), 1'b0, int'($urandom_range(3, 6)), 1'b0);
      end
      check(m_state == StSg, "reach_sg", int'(m_state), int'(StSg));
      step(1'b1, 1'b0, 5, 1'b0);
      tick();
      #2;
      Reset_n = 1'b0;
      #1;
      check(main_lamp == LAMP_R, "async_main", int'(main_lamp), int'(LAMP_R));
      check(side_lamp == LAMP_R, "async_side", int'(side_lamp), int'(LAMP_R));
      check(walk_lamp == 1'b0, "async_walk", int'(walk_lamp), 0);
      check(start_timer == 1'b0, "async_start", int'(start_timer), 0);
      check(state_dbg == 3'(StInit), "async_state", int'(state_dbg), int'(StInit));
      do_reset();

      for (int i = 0; i < 20; i++) begin
         step(1'($urandom % 2), ($urandom % 3) == 0, int'($urandom_range(3, 7)),
              ($urandom % 2) == 0);
      end

      repeat (4) tick();
      check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
